dram_arbiter: RTL and testbench

Shares the single-port data memory (`dRam`) between two requesters: the processor and an external host port used for image loading and result readout. Sits between `processor`/host logic and `dRam`, replacing the direct processor-to-memory wiring. One transaction owns the memory at a time. Grant is round-robin, with a host lock that excludes the processor during image load or readout.

---
 rtl/dram_arbiter_if.sv | 41 ++++
 rtl/dram_arbiter.sv | 115 +++++++++++
 tb/tb_dram_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the dRam arbiter, its two requesters and the data memory.
// The master side drives requests and memory read data; the slave is the arbiter.
interface dram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_ack;
    logic [DATA_W-1:0] p_rdata;
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;
    logic              host_lock;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_ctrl;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output h_req, h_we, h_addr, h_wdata,
        output host_lock, mem_rdata,
        input  p_ack, p_rdata, h_ack, h_rdata,
        input  mem_addr, mem_wdata, mem_ctrl, busy
    );

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  h_req, h_we, h_addr, h_wdata,
        input  host_lock, mem_rdata,
        output p_ack, p_rdata, h_ack, h_rdata,
        output mem_addr, mem_wdata, mem_ctrl, busy
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the single-port dRam between processor and host,
// one transaction at a time, with a host lock that shuts the processor out.
module dram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    dram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RWAIT,
        ACK
    } state_e;

    state_e            state_q;
    logic              last_q;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        ctrl_q;
    logic              p_ack_q;
    logic              h_ack_q;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;
    logic              busy_q;

    logic              p_elig_d;
    logic              h_elig_d;
    logic              gnt_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // last_q/gnt_q: 1 = host, 0 = processor
    always_comb begin
        p_elig_d = bus.p_req & ~bus.host_lock;
        h_elig_d = bus.h_req;
        gnt_d    = h_elig_d & (~p_elig_d | ~last_q);
        we_d     = gnt_d ? bus.h_we    : bus.p_we;
        addr_d   = gnt_d ? bus.h_addr  : bus.p_addr;
        wdata_d  = gnt_d ? bus.h_wdata : bus.p_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= 2'b00;
            p_ack_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            p_rdata_q <= '0;
            h_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            p_ack_q <= 1'b0;
            h_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (p_elig_d | h_elig_d) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        gnt_q   <= gnt_d;
                        last_q  <= gnt_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        ctrl_q  <= we_d ? 2'b10 : 2'b01;
                    end
                end
                ISSUE: begin
                    ctrl_q <= 2'b00;
                    if (we_q) begin
                        state_q <= ACK;
                        p_ack_q <= ~gnt_q;
                        h_ack_q <= gnt_q;
                    end else begin
                        state_q <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (gnt_q) begin
                        h_rdata_q <= bus.mem_rdata;
                    end else begin
                        p_rdata_q <= bus.mem_rdata;
                    end
                    state_q <= ACK;
                    p_ack_q <= ~gnt_q;
                    h_ack_q <= gnt_q;
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_ctrl  = ctrl_q;
    assign bus.p_ack     = p_ack_q;
    assign bus.h_ack     = h_ack_q;
    assign bus.p_rdata   = p_rdata_q;
    assign bus.h_rdata   = h_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level timing and memory model.
module tb_dram_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // dRam stand-in: registered read, write at end of the write-issue cycle
    bit [7:0] dram [1024];
    always @(posedge clk) begin
        if (bus.mem_ctrl == 2'b10) dram[bus.mem_addr[9:0]] <= bus.mem_wdata;
        bus.mem_rdata <= dram[bus.mem_addr[9:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    bit [7:0]    mmem [1024];
    int          nidle = 0;
    int          issue_cyc = -1;
    int          ack_cyc = -1;
    bit          mlast = 1'b1;
    bit          gside;
    bit          gwe;
    bit [AW-1:0] gaddr;
    bit [DW-1:0] gwd;
    bit [DW-1:0] grd;
    bit [AW-1:0] maddr;
    bit [DW-1:0] mwd;
    bit [DW-1:0] mp_rd;
    bit [DW-1:0] mh_rd;
    bit          dp;
    bit          dh;
    int          order[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
        end
    endtask

    task automatic mreset();
        issue_cyc = -1;
        ack_cyc   = -1;
        nidle     = cyc;
        mlast     = 1'b1;
        mp_rd     = '0;
        mh_rd     = '0;
        maddr     = '0;
        mwd       = '0;
    endtask

    task automatic set_p(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.p_req = r; bus.p_we = we; bus.p_addr = a; bus.p_wdata = d;
    endtask

    task automatic set_h(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.h_req = r; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
    endtask

    // One clock cycle: arbitrate in the model, check outputs mid-cycle, advance.
    task automatic tick();
        bit rst, pe, he, pa, ha;
        rst = reset;
        if (!rst && cyc == nidle) begin
            pe = bus.p_req && !bus.host_lock;
            he = bus.h_req;
            if (pe || he) begin
                gside = (pe && he) ? !mlast : he;
                mlast = gside;
                gwe   = gside ? bus.h_we : bus.p_we;
                gaddr = gside ? bus.h_addr : bus.p_addr;
                gwd   = gside ? bus.h_wdata : bus.p_wdata;
                issue_cyc = cyc + 1;
                ack_cyc   = gwe ? cyc + 2 : cyc + 3;
                nidle     = ack_cyc + 1;
                if (gwe) mmem[gaddr[9:0]] = gwd;
                else     grd = mmem[gaddr[9:0]];
            end else begin
                nidle = cyc + 1;
            end
        end
        @(negedge clk);
        dp = 1'b0;
        dh = 1'b0;
        if (!rst) begin
            if (cyc == issue_cyc) begin
                maddr = gaddr;
                mwd   = gwd;
            end
            pa = (cyc == ack_cyc) && !gside;
            ha = (cyc == ack_cyc) && gside;
            if (cyc == ack_cyc && !gwe) begin
                if (gside) mh_rd = grd;
                else       mp_rd = grd;
            end
            chk("p_ack", 32'(bus.p_ack), 32'(pa));
            chk("h_ack", 32'(bus.h_ack), 32'(ha));
            chk("ack_excl", 32'(bus.p_ack & bus.h_ack), 32'd0);
            chk("busy", 32'(bus.busy), 32'(cyc >= issue_cyc && cyc <= ack_cyc));
            chk("mem_ctrl", 32'(bus.mem_ctrl), (cyc == issue_cyc) ? (gwe ? 32'd2 : 32'd1) : 32'd0);
            chk("mem_addr", 32'(bus.mem_addr), 32'(maddr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(mwd));
            chk("p_rdata", 32'(bus.p_rdata), 32'(mp_rd));
            chk("h_rdata", 32'(bus.h_rdata), 32'(mh_rd));
            dp = bus.p_ack;
            dh = bus.h_ack;
            if (dp) order.push_back(0);
            if (dh) order.push_back(1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) mreset();
    endtask

    initial begin
        int np, nh, lp;
        bit got;
        reset = 1'b1;
        bus.host_lock = 1'b0;
        set_p(0, 0, '0, '0);
        set_h(0, 0, '0, '0);
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ctrl", 32'(bus.mem_ctrl), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_acks", 32'({bus.p_ack, bus.h_ack}), 32'd0);
        chk("rst_rdata", 32'({bus.p_rdata, bus.h_rdata}), 32'd0);

        // processor write 0x10 <- 0xA5
        set_p(1, 1, 19'h00010, 8'hA5);
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dp) np++;
        end
        chk("wr_ack_n2", 32'(np), 32'd1);
        set_p(0, 0, '0, '0);

        // host read back of 0x10
        set_h(1, 0, 19'h00010, 8'h00);
        nh = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dh) nh++;
        end
        chk("rd_ack_n3", 32'(nh), 32'd1);
        chk("rd_h_rdata", 32'(bus.h_rdata), 32'hA5);
        chk("rd_p_rdata", 32'(bus.p_rdata), 32'h00);
        set_h(0, 0, '0, '0);
        tick();

        // both saturated after reset: P,H,P,H...
        reset = 1'b1;
        tick();
        reset = 1'b0;
        order.delete();
        np = 0;
        nh = 0;
        set_p(1, 1, 19'h100, 8'h11);
        set_h(1, 1, 19'h200, 8'h22);
        for (int i = 0; i < 40 && (np < 4 || nh < 4); i++) begin
            tick();
            if (dp) begin
                np++;
                if (np < 4) set_p(1, 1, 19'(19'h100 + np), 8'(8'h11 + np));
                else        set_p(0, 0, '0, '0);
            end
            if (dh) begin
                nh++;
                if (nh < 4) set_h(1, 1, 19'(19'h200 + nh), 8'(8'h22 + nh));
                else        set_h(0, 0, '0, '0);
            end
        end
        chk("rr_count", 32'(order.size()), 32'd8);
        for (int k = 0; k < order.size() && k < 8; k++)
            chk("rr_order", 32'(order[k]), 32'(k % 2));

        // host lock excludes the processor
        bus.host_lock = 1'b1;
        set_p(1, 0, 19'h100, 8'h00);
        set_h(1, 0, 19'h200, 8'h00);
        lp = 0;
        nh = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (dp) lp++;
            if (dh) begin
                nh++;
                set_h(1, 0, 19'(19'h201 + nh), 8'h00);
            end
        end
        chk("lock_p_ack", 32'(lp), 32'd0);
        chk("lock_h_served", 32'(nh > 0), 32'd1);
        bus.host_lock = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (dp) begin
                got = 1'b1;
                set_p(0, 0, '0, '0);
            end
            if (dh) set_h(1, 0, 19'h210, 8'h00);
        end
        chk("unlock_p_granted", 32'(got), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dh) set_h(0, 0, '0, '0);
        end
        set_h(0, 0, '0, '0);
        tick();

        // reset during RWAIT of a host read
        set_h(1, 0, 19'h00010, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        set_h(0, 0, '0, '0);
        tick();
        reset = 1'b0;
        chk("rwrst_ctrl", 32'(bus.mem_ctrl), 32'd0);
        chk("rwrst_hack", 32'(bus.h_ack), 32'd0);
        chk("rwrst_hrdata", 32'(bus.h_rdata), 32'd0);
        chk("rwrst_busy", 32'(bus.busy), 32'd0);
        tick();

        // address changed by the requester during ISSUE is ignored
        set_p(1, 1, 19'h00020, 8'h5C);
        tick();
        set_p(1, 1, 19'h00030, 8'h5C);
        tick();
        chk("chg_addr", 32'(bus.mem_addr), 32'h20);
        tick();
        chk("chg_ack", 32'(dp), 32'd1);
        set_p(1, 0, 19'h00020, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        chk("chg_readback", 32'(bus.p_rdata), 32'h5C);
        set_p(0, 0, '0, '0);
        tick();

        // random traffic with a toggling host lock
        for (int i = 0; i < 500; i++) begin
            if (dp || !bus.p_req)
                set_p($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      19'($urandom_range(0, 63)), 8'($urandom));
            if (dh || !bus.h_req)
                set_h($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      19'($urandom_range(0, 63)), 8'($urandom));
            if ($urandom_range(0, 7) == 0) bus.host_lock = !bus.host_lock;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
